bcd_sched: RTL and testbench
============================

BCD_SCHED -- requirements
Module: bcd_sched

Interface
REQ-001 Parameter BITS, default 14: width of the binary input value and of the internal divider datapath.
REQ-002 Parameter DIGITS, default 4: number of decimal digits produced.
REQ-003 Parameter MAXVAL, default 9999: saturation limit; SHALL equal 10^DIGITS - 1.
REQ-004 clk  input  1: single clock; all state SHALL change on its rising edge.
REQ-005 rst_n  input  1: asynchronous, active-low reset.
REQ-006 req_valid  input  1: a conversion request is present on req_value.
REQ-007 req_value  input  BITS: unsigned binary value to convert.
REQ-008 req_ready  output  1: block can accept a request this cycle.
REQ-009 bcd_valid  output  1: one-cycle pulse marking a completed conversion.
REQ-010 bcd_out  output  4*DIGITS: BCD result; digit k occupies bits [4k+3:4k], with k=0 as the ones digit.
REQ-011 overflow  output  1: the most recent result was saturated.
REQ-012 busy  output  1: a conversion is in progress.

Function
REQ-013 The block SHALL sequence one shared restoring divide-by-10 unit that retires 1 quotient bit per cycle; it SHALL NOT instantiate one divider per digit.
REQ-014 The state machine SHALL have states IDLE, DIV, STORE and DONE; these are the only states.
REQ-015 IDLE: req_ready=1, busy=0. A request is accepted on the edge where req_valid=1 and req_ready=1; the FSM then goes to DIV with digit index 0.
REQ-016 On accept, the operand register SHALL load min(req_value, MAXVAL), and an internal ovf flag SHALL load (req_value > MAXVAL).
REQ-017 DIV SHALL last exactly BITS cycles, shifting one dividend bit per cycle into a 4-bit partial remainder; 10 is subtracted whenever the remainder is >= 10.
REQ-018 STORE, 1 cycle:
- write the remainder into digit-slot index of an internal staging register;
- replace the operand with the quotient;
- increment index;
- go to DIV if index < DIGITS-1, else go to DONE.
REQ-019 DONE, 1 cycle:
- copy the staging register to bcd_out and ovf to overflow;
- assert bcd_valid;
- return to IDLE.
REQ-020 Latency: if accept occurs at edge E, bcd_valid SHALL be high in the cycle following edge E + DIGITS*(BITS+1), i.e. 61 cycles with defaults. req_ready SHALL be 1 again in the next cycle.
REQ-021 req_ready=0 and busy=1 in DIV, STORE and DONE; req_valid is ignored there and the request is not queued.
REQ-022 bcd_out and overflow SHALL change only in DONE and hold their value otherwise; partial digits are never visible.
REQ-023 req_value need only be stable on the accept edge; later changes SHALL NOT affect the result.
REQ-024 Back-to-back: if req_valid is held high, the next accept SHALL occur on the first IDLE edge, giving one idle cycle between a DONE cycle and the next DIV.
REQ-025 req_value = 0 SHALL produce all-zero digits. Every digit SHALL be in the range 0..9.

Reset
REQ-026 While rst_n=0:
- state = IDLE;
- bcd_out = 0, overflow = 0, bcd_valid = 0, busy = 0;
- staging register, operand and index = 0;
- req_ready = 1.
REQ-027 rst_n asserted mid-conversion SHALL abort the conversion immediately. No bcd_valid pulse follows, and bcd_out reads 0.
REQ-028 The first accept after reset release SHALL be possible on the first rising edge with rst_n=1.

Verification
REQ-029 req_value=1234, one-cycle req_valid at edge E -> bcd_valid pulse after edge E+60, bcd_out=16'h1234, overflow=0, req_ready low throughout.
REQ-030 req_value=0 -> bcd_out=16'h0000 with bcd_valid pulse; req_value=9999 -> 16'h9999, overflow=0.
REQ-031 req_value=16383 -> bcd_out=16'h9999, overflow=1; a following request of 10000 -> 16'h9999, overflow=1; a following request of 42 -> 16'h0042, overflow=0.
REQ-032 req_valid held high with values 7 then 8 -> two accepts 62 edges apart; bcd_out becomes 16'h0007 and then 16'h0008, each with exactly one bcd_valid pulse.
REQ-033 Accept 5555, drive rst_n=0 at accept+30 for 3 cycles -> all outputs 0 asynchronously, no bcd_valid pulse; after release, request 321 -> 16'h0321 after exactly 61 cycles.
REQ-034 req_value changed every cycle after accept of 2024 -> result still 16'h2024.

Source files
------------

// File: rtl/bcd_sched.sv
// Binary-to-BCD converter built around one shared restoring divide-by-10 unit
// that produces one decimal digit per (BITS+1) cycles, ones digit first.
module bcd_sched #(
    parameter int BITS   = 14,
    parameter int DIGITS = 4,
    parameter int MAXVAL = 9999
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic [BITS-1:0]       req_value,
    output logic                  req_ready,
    output logic                  bcd_valid,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic                  busy
);

    localparam int CW = $clog2(BITS + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [BITS-1:0] MAX_B = BITS'(MAXVAL);

    typedef enum logic [1:0] {IDLE, DIV, STORE, DONE} state_e;

    state_e                state_q;
    logic [BITS-1:0]       operand_q;
    logic [3:0]            rem_q;
    logic [CW-1:0]         cnt_q;
    logic [IW-1:0]         idx_q;
    logic [4*DIGITS-1:0]   staging_q;
    logic [4*DIGITS-1:0]   bcd_out_q;
    logic                  ovf_q;
    logic                  overflow_q;

    logic [4:0]            trial;
    logic                  sub;
    logic [3:0]            rem_d;
    logic [4*DIGITS-1:0]   staging_d;

    // One restoring step: bring in the next dividend bit, subtract 10 if it fits.
    // The remainder stays below 10, so five bits hold the trial value.
    always_comb begin
        trial = {rem_q, operand_q[BITS-1]};
        sub   = (trial >= 5'd10);
        rem_d = trial[3:0];
        if (sub) begin
            rem_d = 4'(trial - 5'd10);
        end
    end

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        staging_d = staging_q;
        staging_d[4*int'(idx_q) +: 4] = rem_q;
    end

    // The dividend shifts out MSB-first while quotient bits fill in from the
    // LSB, so after BITS steps operand_q already holds the quotient.
    // NOTE: state registers use non-blocking assignments; all of them, including staging, clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            operand_q  <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            staging_q  <= '0;
            bcd_out_q  <= '0;
            ovf_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        operand_q <= (req_value > MAX_B) ? MAX_B : req_value;
                        ovf_q     <= (req_value > MAX_B);
                        rem_q     <= '0;
                        cnt_q     <= '0;
                        idx_q     <= '0;
                        state_q   <= DIV;
                    end
                end
                DIV: begin
                    operand_q <= {operand_q[BITS-2:0], sub};
                    rem_q     <= rem_d;
                    cnt_q     <= cnt_q + 1'b1;
                    if (cnt_q == CW'(BITS - 1)) begin
                        state_q <= STORE;
                    end
                end
                STORE: begin
                    staging_q <= staging_d;
                    rem_q     <= '0;
                    cnt_q     <= '0;
                    idx_q     <= idx_q + 1'b1;
                    if (idx_q < IW'(DIGITS - 1)) begin
                        state_q <= DIV;
                    end else begin
                        bcd_out_q  <= staging_d;
                        overflow_q <= ovf_q;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign bcd_valid = (state_q == DONE);
    assign bcd_out   = bcd_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_bcd_sched.sv
// Scoreboard bench for bcd_sched: stimulus pushes expected results and
// completion cycles, a negedge monitor pops and compares on every bcd_valid.
module tb_bcd_sched;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [13:0] req_value = '0;
    logic        req_ready;
    logic        bcd_valid;
    logic [15:0] bcd_out;
    logic        overflow;
    logic        busy;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t sb[$];

    logic [15:0] last_out = '0;
    logic        last_ovf = 1'b0;

    bcd_sched #(.BITS(14), .DIGITS(4), .MAXVAL(9999)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_value (req_value),
        .req_ready (req_ready),
        .bcd_valid (bcd_valid),
        .bcd_out   (bcd_out),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops on each completion, otherwise the outputs must hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_out = '0;
            last_ovf = 1'b0;
        end else if (bcd_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'(bcd_out), 32'hdead);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("bcd_out", 32'(bcd_out), 32'(e.bcd));
                check("overflow", 32'(overflow), 32'(e.ovf));
                check("valid_cycle", 32'(cyc), 32'(e.cyc));
            end
            last_out = bcd_out;
            last_ovf = overflow;
        end else begin
            check("bcd_out_hold", 32'(bcd_out), 32'(last_out));
            check("overflow_hold", 32'(overflow), 32'(last_ovf));
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", 32'(req_ready), 32'd1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    // Issue one single-cycle request; when expect_done is set, also verify
    // the busy window and that the block is ready again right after DONE.
    task automatic convert(input logic [13:0] v, input logic [15:0] b, input logic o,
                           input bit scramble, input bit expect_done);
        int   acc;
        bit   bad = 0;
        exp_t e;
        @(negedge clk);
        wait_ready();
        req_valid = 1'b1;
        req_value = v;
        @(posedge clk);
        #1;
        acc = cyc;
        if (expect_done) begin
            e.bcd = b;
            e.ovf = o;
            e.cyc = acc + 60;
            sb.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
        if (expect_done) begin
            for (int i = 0; i < 61; i++) begin
                if (req_ready || !busy) bad = 1;
                if (scramble) req_value = 14'($urandom);
                @(negedge clk);
            end
            check("busy_window", 32'(bad), 32'd0);
            check("ready_after_done", 32'({req_ready, busy}), 32'b10);
            wait_drain();
        end
    endtask

    initial begin
        int   acc;
        exp_t e;

        #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(bcd_valid), 32'd0);
        check("rst_out", 32'({overflow, bcd_out}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        convert(14'd1234,  16'h1234, 1'b0, 0, 1);
        convert(14'd0,     16'h0000, 1'b0, 0, 1);
        convert(14'd9999,  16'h9999, 1'b0, 0, 1);
        convert(14'd16383, 16'h9999, 1'b1, 0, 1);
        convert(14'd10000, 16'h9999, 1'b1, 0, 1);
        convert(14'd42,    16'h0042, 1'b0, 0, 1);
        convert(14'd2024,  16'h2024, 1'b0, 1, 1);
        convert(14'd9,     16'h0009, 1'b0, 1, 1);
        convert(14'd10,    16'h0010, 1'b0, 0, 1);

        // Back-to-back: valid held high, second accept exactly 62 edges later.
        @(negedge clk);
        wait_ready();
        req_valid = 1'b1;
        req_value = 14'd7;
        @(posedge clk);
        #1;
        acc = cyc;
        e.bcd = 16'h0007; e.ovf = 1'b0; e.cyc = acc + 60;
        sb.push_back(e);
        e.bcd = 16'h0008; e.ovf = 1'b0; e.cyc = acc + 122;
        sb.push_back(e);
        @(negedge clk);
        req_value = 14'd8;
        repeat (61) @(posedge clk);
        @(negedge clk);
        check("b2b_idle_gap_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b_second_accept", 32'(busy), 32'd1);
        wait_drain();

        // Abort mid-conversion; outputs drop asynchronously, no completion.
        convert(14'd5555, 16'h0000, 1'b0, 0, 0);
        repeat (29) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out", 32'({overflow, bcd_out}), 32'd0);
        check("abort_ready_busy", 32'({req_ready, busy, bcd_valid}), 32'b100);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        convert(14'd321, 16'h0321, 1'b0, 0, 1);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
